prio_encoder_arb: RTL and testbench

Parametrised, registered successor to the combinational 8-to-3 priority encoder. Collects request bits from an N-wide input into a sticky pending register and issues one encoded index per accepted transfer over a valid/ready output. Priority is either fixed (highest index wins) or round-robin. It sits between request sources and any consumer that needs one serialised index stream, and replaces the combinational encoder wherever grants must not be lost under backpressure.

---
 rtl/prio_encoder_arb.sv | 53 +++++
 tb/tb_prio_encoder_arb.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/prio_encoder_arb.sv
// prio_encoder_arb: registered fixed/round-robin priority arbiter; in/e/rr_mode requests -> out/out_valid grant stream (out_ready backpressure), pending = ungranted requests
module prio_encoder_arb #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         e,
  input  logic [N-1:0] in,
  input  logic         rr_mode,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out,
  output logic [N-1:0] pending
);
  logic [N-1:0] cand;
  logic [W-1:0] sel, ptr, j;
  logic         load;
  always_comb begin
    cand = pending | (e ? in : '0);
    load = e && (|cand) && (!out_valid || out_ready);
    sel  = '0;
    j    = '0;
    if (rr_mode) begin
      for (int i = N - 1; i >= 0; i--) begin
        j = W'((int'(ptr) + N - i) % N);
        if (cand[j]) sel = j;
      end
    end else begin
      for (int i = 0; i < N; i++)
        if (cand[W'(i)]) sel = W'(i);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      pending   <= '0;
      ptr       <= W'(N - 1);
    end else if (load) begin
      out       <= sel;
      out_valid <= 1'b1;
      pending   <= cand & ~(N'(1) << sel);
      ptr       <= (sel == '0) ? W'(N - 1) : sel - W'(1);
    end else begin
      pending <= cand;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out       <= '0;
      end
    end
  end
endmodule

// File: tb/tb_prio_encoder_arb.sv
// tb_prio_encoder_arb: scoreboard bench for prio_encoder_arb (N=8 main instance, N=4 parameter instance)
module tb_prio_encoder_arb;
  logic       clk = 1'b0, rst = 1'b1;
  logic       e = 1'b0, rr_mode = 1'b0, out_ready = 1'b0, out_valid;
  logic [7:0] in = '0, pending;
  logic [2:0] out, exp_out;
  logic       e4 = 1'b0, out_valid4;
  logic [3:0] in4 = '0, pending4;
  logic [1:0] out4;
  int         total = 0, bad = 0;
  logic [2:0] q[$];

  always #5 clk = ~clk;

  prio_encoder_arb #(.N(8)) dut (
    .clk(clk), .rst(rst), .e(e), .in(in), .rr_mode(rr_mode), .out_ready(out_ready),
    .out_valid(out_valid), .out(out), .pending(pending)
  );

  prio_encoder_arb #(.N(4), .W(2)) dut4 (
    .clk(clk), .rst(rst), .e(e4), .in(in4), .rr_mode(1'b0), .out_ready(1'b1),
    .out_valid(out_valid4), .out(out4), .pending(pending4)
  );

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got out=%0d, none expected", out);
      end else begin
        exp_out = q.pop_front();
        if (out !== exp_out) begin
          bad++;
          $display("FAIL sb_grant: got out=%0d want %0d", out, exp_out);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    step(2);
    chk("rst_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_pending", pending, 0);
    rst = 1'b0;
    step();
    // mid-operation reset with a held grant and pending = A5
    e = 1'b1; rr_mode = 1'b1; out_ready = 1'b0; in = 8'h80;
    q.push_back(3'd7);
    step();
    in = 8'hA5;
    step();
    chk("pre_rst_pending", pending, 8'hA5);
    chk("pre_rst_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_out", out, 0);
    chk("async_rst_pending", pending, 0);
    q.delete();
    step();
    rst = 1'b0;
    // first round-robin grant after reset starts at 7
    in = 8'hFF; out_ready = 1'b1;
    for (int k = 7; k >= 0; k--) q.push_back(3'(k));
    step();
    chk("rr_first", out, 7);
    in = 8'h00;
    step(8);
    chk("rr_drain_valid", out_valid, 0);
    chk("rr_drain_pending", pending, 0);
    // fixed drain
    rr_mode = 1'b0; in = 8'b0010_0110;
    q.push_back(3'd5); q.push_back(3'd2); q.push_back(3'd1);
    step();
    in = 8'h00;
    step(3);
    chk("fix_drain_valid", out_valid, 0);
    chk("fix_drain_out", out, 0);
    chk("fix_drain_pending", pending, 0);
    // enable gating
    e = 1'b0; in = 8'hFF;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("gate_valid", out_valid, 0);
      chk("gate_pending", pending, 0);
    end
    e = 1'b1; in = 8'h00;
    step(2);
    chk("gate_idle_valid", out_valid, 0);
    // backpressure
    out_ready = 1'b0; in = 8'h81;
    q.push_back(3'd7); q.push_back(3'd0);
    step();
    in = 8'h00;
    for (int c = 0; c < 4; c++) begin
      chk("bp_out", out, 7);
      chk("bp_valid", out_valid, 1);
      chk("bp_pending", pending, 8'h01);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_rel_out", out, 0);
    chk("bp_rel_valid", out_valid, 1);
    step();
    chk("bp_end_valid", out_valid, 0);
    // fairness: round-robin rotates, fixed sticks at 7
    rr_mode = 1'b1; in = 8'hFF;
    for (int c = 0; c < 10; c++) q.push_back(3'((7 - c + 8) % 8));
    step(10);
    rr_mode = 1'b0;
    repeat (4) q.push_back(3'd7);
    step(4);
    in = 8'h00;
    for (int k = 6; k >= 0; k--) q.push_back(3'(k));
    step(7);
    chk("fair_pending", pending, 0);
    step();
    chk("fair_end_valid", out_valid, 0);
    chk("sb_left", q.size(), 0);
    // N = 4 instance
    e4 = 1'b1; in4 = 4'b0001;
    step();
    chk("n4_valid", out_valid4, 1);
    chk("n4_out", out4, 0);
    in4 = 4'b0000;
    step();
    chk("n4_end_valid", out_valid4, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
